// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M op encodings, sequencer state encoding and op-class predicates
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response handshake bundle between EX control and the mul/div sequencer
interface muldiv_seq_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: shared add/sub step unit; o_carry is carry-out on add and not-borrow on subtract
module muldiv_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, (i_sub ? ~i_b : i_b)} + (W+1)'(i_sub);
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer, one bit per cycle
// Optional feature: define MULDIV_BYPASS_EN to skip the iteration loop for
// divide-by-zero, signed overflow and zero multiply operands.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_count;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_res;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg;
    logic             w_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_b_zero;
    logic             w_bypass;
    logic [XLEN-1:0]  w_sel;
    logic [XLEN-1:0]  w_fix;
    logic [XLEN:0]    w_step_a;
    logic [XLEN:0]    w_step_b;
    logic             w_step_sub;
    logic [XLEN:0]    w_sum;
    logic             w_carry;

    // In PREP r_lo/r_b still hold the raw rs1/rs2 captured at accept
    assign w_div    = is_div(r_op);
    assign w_a_neg  = is_signed_a(r_op) & r_lo[XLEN-1];
    assign w_b_neg  = is_signed_b(r_op) & r_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? -r_lo : r_lo;
    assign w_abs_b  = w_b_neg ? -r_b : r_b;
    assign w_b_zero = r_b == '0;

`ifdef MULDIV_BYPASS_EN
    logic w_ovf;
    assign w_ovf    = ((r_op == OP_DIV) || (r_op == OP_REM)) &&
                      (r_lo == {1'b1, {(XLEN-1){1'b0}}}) && (&r_b);
    assign w_bypass = w_div ? (w_b_zero | w_ovf) : ((r_lo == '0) | w_b_zero);
`else
    assign w_bypass = 1'b0;
`endif

    // Unsigned magnitude to report: low product, high product, remainder or quotient
    assign w_sel = (r_op == OP_MUL) ? r_lo : (w_div ? (r_op[1] ? r_hi : r_lo) : r_hi);

    // Negating a 64-bit product: high word borrows unless the low word is zero
    assign w_fix = !r_neg ? w_sel :
                   (!w_div && (r_op != OP_MUL) && (r_lo != '0)) ? ~r_hi : w_sum[XLEN-1:0];

    // Step unit operand steering: shift-add, trial subtract, or 0 - x in FIX
    always_comb begin
        w_step_a   = '0;
        w_step_b   = {1'b0, w_sel};
        w_step_sub = 1'b1;
        if (r_state == S_CALC) begin
            w_step_a   = w_div ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
            w_step_b   = {1'b0, (w_div || r_lo[0]) ? r_b : '0};
            w_step_sub = w_div;
        end
    end

    muldiv_step #(.W(XLEN + 1)) u_step (
        .i_a     (w_step_a),
        .i_b     (w_step_b),
        .i_sub   (w_step_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush overrides every transition including accept and handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.in_valid ? S_PREP : S_IDLE;
            S_PREP:  w_next = w_bypass ? S_FIX : S_CALC;
            S_CALC:  w_next = (r_count == '0) ? S_FIX : S_CALC;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = bus.out_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    // Outputs decoded from state; result and tag come straight from registers
    always_comb begin
        bus.in_ready   = r_state == S_IDLE;
        bus.busy       = r_state != S_IDLE;
        bus.out_valid  = r_state == S_DONE;
        bus.out_result = r_res;
        bus.out_tag    = r_tag;
    end

    // Datapath: capture, sign-strip, iterate, then fix up and register the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= '0;
            r_tag   <= '0;
            r_neg   <= 1'b0;
        end else if (!bus.flush) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= bus.in_op;
                        r_lo  <= bus.in_a;
                        r_b   <= bus.in_b;
                        r_tag <= bus.in_tag;
                    end
                end
                S_PREP: begin
                    r_count <= 5'd31;
                    r_hi    <= '0;
                    r_lo    <= w_abs_a;
                    r_b     <= w_abs_b;
                    r_neg   <= !w_div ? (w_a_neg ^ w_b_neg) :
                               r_op[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & ~w_b_zero);
`ifdef MULDIV_BYPASS_EN
                    if (w_bypass) begin
                        r_hi <= (w_div && w_b_zero) ? w_abs_a : '0;
                        r_lo <= !w_div ? '0 : (w_b_zero ? '1 : w_abs_a);
                    end
`endif
                end
                S_CALC: begin
                    r_count <= r_count - 5'd1;
                    if (w_div) begin
                        r_hi <= w_carry ? w_sum[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                        r_lo <= {r_lo[XLEN-2:0], w_carry};
                    end else begin
                        {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
                    end
                end
                S_FIX:   r_res <= w_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq (latency follows MULDIV_BYPASS_EN)
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_ok  = 0;

`ifdef MULDIV_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Latency counts rising edges from the accept edge (inclusive) to the edge raising out_valid
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input bit byp, input int hold);
        int lat;
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_op    = ~op;
        bus.in_tag   = ~tag;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), (BYP_EN && byp) ? 32'd3 : 32'd35);
        chk({name, "_result"}, bus.out_result, exp);
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_result"}, bus.out_result, exp);
            chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_tag", 32'(bus.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // op codes: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0, 0);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1'b0, 10);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1'b0, 0);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b0, 0);
        run_op("mulh_n",  3'd1, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFFF, 1'b0, 0);
        run_op("mul_n",   3'd0, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, 1'b0, 0);
        run_op("mulhu_s", 3'd3, 32'h12345678, 32'h10,       5'd7,  32'h00000001, 1'b0, 0);
        run_op("mul_z",   3'd0, 32'd0,        32'd5,        5'd8,  32'd0,        1'b1, 0);
        run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 1'b0, 0);
        run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 1'b0, 0);
        run_op("divu",    3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       1'b0, 0);
        run_op("remu",    3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        1'b0, 0);
        run_op("divu_z",  3'd5, 32'h55,       32'd0,        5'd13, 32'hFFFFFFFF, 1'b1, 0);
        run_op("remu_z",  3'd7, 32'h1234,     32'd0,        5'd14, 32'h1234,     1'b1, 0);
        run_op("div_z",   3'd4, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFF, 1'b1, 0);
        run_op("rem_z",   3'd6, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB, 1'b1, 0);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1'b1, 0);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1'b1, 0);

        // flush during the fifth CALC cycle: the op vanishes and the unit is reusable
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd5;
        bus.in_a     = 32'd1000;
        bus.in_b     = 32'd3;
        bus.in_tag   = 5'd19;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd20, 32'd333, 1'b0, 0);

        // asynchronous reset mid-operation returns outputs to reset values at once
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd9;
        bus.in_tag   = 5'd21;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_tag", 32'(bus.out_tag), 32'd0);
        chk("arst_result", bus.out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 3'd0, 32'd9, 32'd9, 5'd22, 32'd81, 1'b0, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
